// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types for the memory request sequencer.
//   state_e : sequencer FSM states (IDLE, ISSUE, WAIT, RESP)
//   cmd_t   : queued command {write, addr, wdata} at the package widths
package mem_req_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: request queue for the sequencer.
//   clk, rst_n     : clock, async active-low reset (pointers/count only)
//   push_i, wdata_i: write an entry (ignored when full)
//   pop_i, rdata_o : remove the head entry (ignored when empty); rdata_o is the head
//   full_o, empty_o, count_o : occupancy, all from the registered count
module mem_req_fifo #(
    parameter  int WIDTH = 43,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: queues read/write requests and runs them one at a time
// against a memory stage, with a per-command completion timeout.
//   req_*  : upstream request (valid/ready) pushed into the queue
//   rsp_*  : in-order response (valid/ready); rsp_err = timed out
//   mem_*  : one-cycle strobe, address/data held through the wait, completion input
//   busy   : FSM not idle or queue non-empty
module mem_req_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready,
    output logic                  busy
);

    import mem_req_pkg::*;

    localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    state_e                state_q;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  cmd_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic                  wr_en_q, rd_en_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  fifo_full, fifo_empty, pop;
    logic [CW-1:0]         fifo_count;
    logic [CMD_W-1:0]      head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    assign {head_write, head_addr, head_wdata} = head;

    // Pop only from IDLE, which also enforces a single outstanding command.
    assign pop       = (state_q == IDLE) && !fifo_empty;
    assign req_ready = !fifo_full;

    mem_req_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid && req_ready),
        .wdata_i ({req_write, req_addr, req_wdata}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Saturating increment; the timer never wraps back to zero.
    assign timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            cmd_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        // Strobe is registered here so it is high exactly in ISSUE.
                        cmd_write_q   <= head_write;
                        mem_addr_q    <= head_addr;
                        mem_wr_data_q <= head_wdata;
                        wr_en_q       <= head_write;
                        rd_en_q       <= !head_write;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Completion is checked first so it beats a coincident timeout.
                    if (mem_ready) begin
                        rsp_rdata_q <= cmd_write_q ? '0 : mem_rd_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        timer_q <= timer_d;
                        if (timer_q == TW'(TIMEOUT)) begin
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: directed + randomized bench for mem_req_sequencer.
// A memory responder answers each strobe after a planned or random delay; a
// scoreboard of commands and expected responses is derived from that delay.
module tb_mem_req_sequencer;
    import mem_req_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int T  = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr_en, mem_rd_en, mem_ready, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;

    mem_req_sequencer #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FIFO_DEPTH (4), .TIMEOUT (T)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_err (rsp_err),
        .mem_wr_en (mem_wr_en), .mem_rd_en (mem_rd_en), .mem_addr (mem_addr),
        .mem_wr_data (mem_wr_data), .mem_rd_data (mem_rd_data),
        .mem_ready (mem_ready), .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int d; logic [DW-1:0] data; } plan_t;
    typedef struct { logic [DW-1:0] rdata; logic err; int strobe_cyc; int lat; } exp_t;

    plan_t plan_q[$];
    cmd_t  exp_cmd[$];
    exp_t  exp_rsp[$];

    int total = 0, bad = 0, cyc = 0;
    int strobe_cnt = 0, rsp_cnt = 0, err_cnt = 0, n_req = 0;
    int last_strobe_cyc = 0, push_cyc = 0, rand_max = 6;
    logic [DW-1:0] last_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst(input string t);
        chk({t, "_rsp_valid"}, rsp_valid, 0);
        chk({t, "_rsp_err"}, rsp_err, 0);
        chk({t, "_rsp_rdata"}, rsp_rdata, 0);
        chk({t, "_wr_en"}, mem_wr_en, 0);
        chk({t, "_rd_en"}, mem_rd_en, 0);
        chk({t, "_mem_addr"}, mem_addr, 0);
        chk({t, "_mem_wr_data"}, mem_wr_data, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_req_ready"}, req_ready, 1);
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   g;
        cmd_t c;
        g = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && g < 300) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        chk("push_accept", req_ready, 1);
        c.write = w; c.addr = a; c.wdata = d;
        exp_cmd.push_back(c);
        push_cyc = cyc;
        n_req++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string t);
        int g;
        g = 0;
        while (rsp_cnt < n_req && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        chk(t, rsp_cnt, n_req);
    endtask

    // Memory responder: answers each strobe after d cycles (ready in cycle strobe+d).
    initial begin : responder
        int pend, wleft;
        logic prev_str, str;
        logic [DW-1:0] pdata, cur_wdata;
        logic [AW-1:0] cur_addr;
        cmd_t  c;
        plan_t p;
        exp_t  e;
        pend = 0; wleft = 0; prev_str = 0; pdata = '0; cur_addr = '0; cur_wdata = '0;
        mem_ready = 1'b0; mem_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rd_data = $urandom;
            if (!rst_n) begin
                pend = 0; wleft = 0; prev_str = 0;
                continue;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin mem_ready = 1'b1; mem_rd_data = pdata; end
            end
            str = mem_wr_en | mem_rd_en;
            if (wleft > 0) begin
                wleft--;
                chk("wait_no_strobe", str, 0);
                chk("wait_addr_hold", mem_addr, cur_addr);
                chk("wait_wdata_hold", mem_wr_data, cur_wdata);
            end
            if (str) begin
                chk("strobe_onehot", 32'(mem_wr_en) + 32'(mem_rd_en), 1);
                chk("strobe_one_cycle", prev_str, 0);
                chk("one_outstanding", exp_rsp.size(), 0);
                if (exp_cmd.size() == 0) chk("strobe_unexpected", exp_cmd.size(), 1);
                else begin
                    c = exp_cmd.pop_front();
                    chk("strobe_write", mem_wr_en, c.write);
                    chk("strobe_addr", mem_addr, c.addr);
                    chk("strobe_wdata", mem_wr_data, c.wdata);
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else begin p.d = $urandom_range(1, rand_max); p.data = $urandom; end
                    e.err        = (p.d > T + 1);
                    e.rdata      = (c.write || e.err) ? '0 : p.data;
                    e.lat        = e.err ? T + 2 : p.d + 1;
                    e.strobe_cyc = cyc;
                    exp_rsp.push_back(e);
                    pend = p.d; pdata = p.data;
                    wleft = e.err ? T + 1 : p.d;
                    cur_addr = c.addr; cur_wdata = c.wdata;
                    last_strobe_cyc = cyc;
                    strobe_cnt++;
                end
            end
            prev_str = str;
        end
    end

    // Response monitor: order, contents, latency and stability under backpressure.
    initial begin : monitor
        logic pv, pr, pe, pending;
        logic [DW-1:0] pd;
        int vstart;
        exp_t e;
        pv = 0; pr = 0; pe = 0; pd = '0; vstart = 0;
        forever begin
            @(posedge clk); #3;
            if (!rst_n) begin pv = 0; pr = 0; continue; end
            pending = pv && !pr;
            if (pending) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_rdata", rsp_rdata, pd);
                chk("hold_err", rsp_err, pe);
            end else if (rsp_valid) vstart = cyc;
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", exp_rsp.size(), 1);
                else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_latency", vstart - e.strobe_cyc, e.lat);
                    rsp_cnt++;
                    last_rdata = rsp_rdata;
                    if (rsp_err) err_cnt++;
                end
            end
            pv = rsp_valid; pr = rsp_ready; pd = rsp_rdata; pe = rsp_err;
        end
    end

    initial begin : main
        int s0, r0, e0;
        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_rst("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // single write, ready 2 cycles after strobe
        plan_q.push_back('{2, 32'h0});
        s0 = strobe_cnt;
        push(1'b1, 10'h005, 32'hDEADBEEF);
        chk("wr_busy", busy, 1);
        wait_rsp("wr_done");
        chk("wr_strobes", strobe_cnt - s0, 1);
        chk("wr_strobe_lat", last_strobe_cyc - push_cyc, 2);
        chk("wr_rdata", last_rdata, 0);
        repeat (2) @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // read at top address
        plan_q.push_back('{1, 32'h12345678});
        push(1'b0, 10'h3FF, $urandom);
        wait_rsp("rd_done");
        chk("rd_rdata", last_rdata, 32'h12345678);

        // fill while the consumer stalls, then hold in RESP for 10 cycles
        rsp_ready = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            plan_q.push_back('{1, $urandom});
            push(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
        chk("fill_req_ready", req_ready, 0);
        repeat (10) @(posedge clk); #1;
        chk("bp_valid", rsp_valid, 1);
        chk("bp_strobes", strobe_cnt - s0, 1);
        rsp_ready = 1'b1;
        wait_rsp("fill_done");
        chk("fill_strobes", strobe_cnt - s0, 5);

        // timeout, boundary (ready on the timeout cycle wins), just-late, normal
        e0 = err_cnt;
        plan_q.push_back('{100, 32'h0});
        plan_q.push_back('{T + 1, 32'hA5A5_0001});
        plan_q.push_back('{T + 2, 32'hA5A5_0002});
        plan_q.push_back('{1, 32'hA5A5_0003});
        push(1'b0, 10'h011, '0);
        push(1'b0, 10'h022, '0);
        push(1'b1, 10'h033, 32'h0BAD_F00D);
        push(1'b0, 10'h044, '0);
        wait_rsp("to_done");
        chk("to_errors", err_cnt - e0, 2);
        chk("to_last_rdata", last_rdata, 32'hA5A5_0003);

        // randomized traffic with random consumer stalls and delays past the timeout
        rand_max = T + 4;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            push(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
        rsp_ready = 1'b1;
        wait_rsp("rand_done");
        rand_max = 6;

        // reset mid-WAIT with two commands queued
        plan_q.push_back('{100, 32'h0});
        push(1'b0, 10'h101, '0);
        push(1'b1, 10'h102, 32'h1111_2222);
        push(1'b0, 10'h103, '0);
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1 chk_rst("midrst");
        exp_cmd.delete(); exp_rsp.delete(); plan_q.delete();
        n_req = rsp_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        s0 = strobe_cnt; r0 = rsp_cnt;
        repeat (20) @(posedge clk); #1;
        chk("post_rst_strobes", strobe_cnt - s0, 0);
        chk("post_rst_rsps", rsp_cnt - r0, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", req_ready, 1);
        plan_q.push_back('{3, 32'hCAFE_0042});
        push(1'b0, 10'h2A5, '0);
        wait_rsp("post_rst_done");
        chk("post_rst_rdata", last_rdata, 32'hCAFE_0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
